// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: WIDTH-bit add/sub done one nibble per clock through a single 4-bit CLA slice.
module carry_look_ahead_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] g, p;
  logic [4:0] c;
  assign g = a & b;
  assign p = a ^ b;
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);
  assign sum  = p ^ c[3:0];
  assign cout = c[4];
endmodule

module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = $clog2(NIB + 1);
  if (WIDTH % 4 != 0 || WIDTH < 4) begin : g_bad_width
    $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and at least 4");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, acc_d, result_q, b_in;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, sa_q, sb_q, in_ready_q, out_valid_q, cout_q, ov_q;
  logic [3:0]       sum4;
  logic             c4, last;
  carry_look_ahead_4bit u_slice (
    .a(a_q[3:0]), .b(b_q[3:0]), .cin(carry_q), .sum(sum4), .cout(c4)
  );
  assign b_in  = sub ? ~b : b;
  assign acc_d = WIDTH'({sum4, acc_q} >> 4);
  assign last  = cnt_q == CW'(NIB - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      cout_q      <= 1'b0;
      ov_q        <= 1'b0;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_q        <= a;
          b_q        <= b_in;
          carry_q    <= sub;
          sa_q       <= a[WIDTH-1];
          sb_q       <= b_in[WIDTH-1];
          cnt_q      <= '0;
          acc_q      <= '0;
          in_ready_q <= 1'b0;
          state_q    <= RUN;
        end
        RUN: begin
          a_q     <= a_q >> 4;
          b_q     <= b_q >> 4;
          carry_q <= c4;
          acc_q   <= acc_d;
          cnt_q   <= cnt_q + CW'(1);
          if (last) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            result_q    <= acc_d;
            cout_q      <= c4;
            ov_q        <= (sa_q == sb_q) && (acc_d[WIDTH-1] != sa_q);
          end
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign cout      = cout_q;
  assign overflow  = ov_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb_nibble_serial_adder_ctrl: scoreboard bench for the 16-bit and 4-bit serial adder.
module tb_nibble_serial_adder_ctrl;
  logic        clk = 0, rst = 1;
  logic        in_valid = 0, sub = 0, out_ready = 1;
  logic [15:0] a = 0, b = 0;
  logic        in_ready, out_valid, cout, overflow;
  logic [15:0] result;
  logic        in_valid4 = 0, sub4 = 0;
  logic [3:0]  a4 = 0, b4 = 0;
  logic        in_ready4, out_valid4, cout4, overflow4;
  logic [3:0]  result4;
  int total = 0, bad = 0;
  logic [17:0] sb_q[$];
  always #5 clk = ~clk;
  nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .cout(cout), .overflow(overflow)
  );
  nibble_serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4), .sub(sub4),
    .out_valid(out_valid4), .out_ready(1'b1), .result(result4), .cout(cout4), .overflow(overflow4)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic s);
    logic [16:0] w;
    logic [15:0] r;
    logic c, v;
    w = {1'b0, x} + {1'b0, y};
    r = s ? x - y : w[15:0];
    c = s ? (x >= y) : w[16];
    v = s ? (x[15] != y[15] && r[15] != x[15]) : (x[15] == y[15] && r[15] != x[15]);
    return {c, v, r};
  endfunction
  task automatic accept(input logic [15:0] x, input logic [15:0] y, input logic s);
    int n = 0;
    while (!in_ready && n < 50) begin step(); n++; end
    chk("in_ready_wait", 32'(in_ready), 1);
    a = x; b = y; sub = s; in_valid = 1;
    sb_q.push_back(model(x, y, s));
    step();
    in_valid = 0;
  endtask
  task automatic wait_result(input string tag);
    int n = 0;
    logic [17:0] e;
    while (!out_valid && n < 20) begin step(); n++; end
    chk({tag, "_lat"}, n, 4);
    chk({tag, "_in_ready_done"}, 32'(in_ready), 0);
    e = (sb_q.size() != 0) ? sb_q.pop_front() : 18'h3ffff;
    chk({tag, "_res"}, {cout, overflow, result}, e);
  endtask
  task automatic op(input string tag, input logic [15:0] x, input logic [15:0] y, input logic s);
    accept(x, y, s);
    wait_result(tag);
    step();
    chk({tag, "_ov_drop"}, 32'(out_valid), 0);
    chk({tag, "_in_ready_back"}, 32'(in_ready), 1);
  endtask
  initial begin
    logic [17:0] held;
    repeat (2) step();
    rst = 0;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_outs", {cout, overflow, result}, 0);
    op("add_2233", 16'h1234, 16'h0FFF, 0);
    chk("add_2233_const", {cout, overflow, result}, {2'b00, 16'h2233});
    op("add_wrap", 16'hFFFF, 16'h0001, 0);
    chk("add_wrap_const", {cout, overflow, result}, {2'b10, 16'h0000});
    op("add_ovf", 16'h7FFF, 16'h0001, 0);
    chk("add_ovf_const", {cout, overflow, result}, {2'b01, 16'h8000});
    op("sub_neg", 16'h0005, 16'h0007, 1);
    chk("sub_neg_const", {cout, overflow, result}, {2'b00, 16'hFFFE});
    op("sub_ovf", 16'h8000, 16'h0001, 1);
    chk("sub_ovf_const", {cout, overflow, result}, {2'b11, 16'h7FFF});
    out_ready = 0;
    accept(16'h4321, 16'h1111, 1);
    wait_result("bp");
    held = {cout, overflow, result};
    a = 16'h1111; b = 16'h1111; sub = 0; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_hold", {cout, overflow, result}, held);
    end
    in_valid = 0;
    out_ready = 1;
    step();
    chk("bp_release_ready", 32'(in_ready), 1);
    chk("bp_release_valid", 32'(out_valid), 0);
    op("after_bp", 16'h1111, 16'h1111, 0);
    chk("after_bp_const", result, 16'h2222);
    a = 16'hABCD; b = 16'h1234; sub = 0; in_valid = 1;
    step();
    in_valid = 0;
    step();
    rst = 1;
    step();
    rst = 0;
    chk("abort_in_ready", 32'(in_ready), 1);
    chk("abort_out_valid", 32'(out_valid), 0);
    chk("abort_result", result, 0);
    repeat (6) begin
      step();
      chk("abort_no_valid", 32'(out_valid), 0);
    end
    op("post_abort", 16'h0001, 16'h0001, 0);
    chk("post_abort_const", result, 16'h0002);
    for (int i = 0; i < 10; i++)
      op("rand", 16'($urandom), 16'($urandom), 1'($urandom));
    begin
      int n = 0;
      a4 = 4'h9; b4 = 4'h9; sub4 = 0; in_valid4 = 1;
      step();
      in_valid4 = 0;
      while (!out_valid4 && n < 10) begin step(); n++; end
      chk("w4_lat", n, 1);
      chk("w4_res", {cout4, overflow4, result4}, {2'b11, 4'h2});
      step();
      chk("w4_ready", 32'(in_ready4), 1);
      a4 = 4'h3; b4 = 4'h5; sub4 = 1; in_valid4 = 1;
      step();
      in_valid4 = 0;
      n = 0;
      while (!out_valid4 && n < 10) begin step(); n++; end
      chk("w4_sub", {cout4, overflow4, result4}, {2'b00, 4'hE});
    end
    chk("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
